imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
// - Inverse of the immediate sign-extend decoder: packs a 32-bit signed immediate into the
//   RV32I instruction bit positions for format imm_sel, merged over a base instruction word.
// - Feeds the self-test instruction generator / loader path; valid/ready in, valid/ready out,
//   1-cycle latency, full throughput via a 2-entry skid buffer. Flags unencodable immediates.
// PARAMETERS
// - ERR_CNT_W   8   width of saturating error counter err_count
// PORTS
// - clk        in   1          clock, all state on rising edge
// - rst        in   1          reset, asynchronous, active-low
// - in_valid   in   1          input beat valid
// - in_ready   out  1          input beat accepted when in_valid && in_ready
// - imm_sel    in   3          0=I 1=S 2=B 3=U 4=J (same coding as decoder); 5-7 illegal
// - imm        in   32         signed immediate value (byte offset for B/J)
// - base_instr in   32         instruction word; its immediate-field bits are ignored/overwritten
// - out_valid  out  1          output beat valid
// - out_ready  in   1          downstream accept
// - out_instr  out  32         encoded instruction
// - out_err    out  1          immediate not representable in selected format
// - err_clr    in   1          synchronous clear of err_count
// - err_count  out  ERR_CNT_W  count of out_err beats handed off, saturating
// BEHAVIOUR
// - Packing (non-listed bits taken from base_instr):
//   I: [31:20]=imm[11:0]    S: [31:25]=imm[11:5], [11:7]=imm[4:0]
//   B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
//   U: [31:12]=imm[31:12]   J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
//   illegal sel: out_instr=base_instr, out_err=1 (regardless of macro).
// - Range: I/S -2048..2047; B -4096..4094 and imm[0]=0; U imm[11:0]=0; J -2^20..2^20-2, imm[0]=0.
// - Latency: accepted beat appears on out_* the next cycle; order preserved, no drops/dups.
// - Skid buffer: out register + 1 skid register. in_ready = !skid_full (registered, not
//   combinational on out_ready). Stall (out_valid && !out_ready): out_* held stable; an accepted
//   beat goes to skid, in_ready drops next cycle. On out handshake skid moves to output.
// - Simultaneous in and out handshake with empty skid: new beat loads output directly.
// - err_count: +1 on out_valid&&out_ready&&out_err; saturates at all-ones; err_clr wins over
//   a same-cycle increment (result 0).
// - Reset (any time, incl. mid-stall): out_valid=0, out_instr=0, out_err=0, skid empty,
//   err_count=0; in-flight beats discarded; in_ready=1 from first cycle after rst releases.
// CONFIGURATION
// - IMM_ENC_STRICT_EN defined: out-of-range/misaligned imm sets out_err=1, out_instr still
//   holds truncated packing. Undefined: no range/alignment checks, bits silently truncated,
//   out_err only for illegal imm_sel.
// TESTING
// - I: base=0x0004A303, imm=-4, sel=0 -> out_instr=0xFFC4A303, out_err=0, one cycle later.
// - S: base=0x0064A023, imm=8, sel=1 -> 0x0064A423; B: base=0x00420063, imm=-12, sel=2 -> 0xFE420AE3.
// - Strict: sel=0 imm=2048 -> out_err=1, err_count 0->1; sel=2 imm=3 -> out_err=1;
//   without macro both out_err=0 and err_count stays 0. sel=6 -> out_instr=base, out_err=1.
// - Backpressure: hold out_ready=0, push 3 beats -> 2 accepted, in_ready=0; release ->
//   beats emerge in order on consecutive cycles, in_ready back to 1.
// - Counter: 2^ERR_CNT_W+3 error beats -> err_count=0xFF; err_clr with error beat same cycle -> 0.
// - Reset asserted async during stall with skid full -> out_valid=0 immediately, no stale beat
//   after release; U: base=0x00000537, imm=0x12345000, sel=3 -> 0x12345537.

Source files
------------

// File: rtl/imm_encoder.sv
// RV32I immediate encoder with valid/ready handshake, 1-cycle latency and a 2-entry skid buffer.
// Define IMM_ENC_STRICT_EN to flag out-of-range or misaligned immediates on out_err.
`timescale 1ns/1ps
module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_sel,
  input  logic [31:0]          imm,
  input  logic [31:0]          base_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] SEL_I = 3'd0;
  localparam logic [2:0] SEL_S = 3'd1;
  localparam logic [2:0] SEL_B = 3'd2;
  localparam logic [2:0] SEL_U = 3'd3;
  localparam logic [2:0] SEL_J = 3'd4;

  // Scatter the immediate into the format's field positions; other bits come from base.
  function automatic logic [31:0] pack_imm(input logic [2:0] sel,
                                           input logic signed [31:0] v,
                                           input logic [31:0] base);
    logic [31:0] r;
    r = base;
    case (sel)
      SEL_I: r = {v[11:0], base[19:0]};
      SEL_S: r = {v[11:5], base[24:12], v[4:0], base[6:0]};
      SEL_B: r = {v[12], v[10:5], base[24:12], v[4:1], v[11], base[6:0]};
      SEL_U: r = {v[31:12], base[11:0]};
      SEL_J: r = {v[20], v[10:1], v[11], v[19:12], base[11:0]};
      default: r = base;
    endcase
    return r;
  endfunction

`ifdef IMM_ENC_STRICT_EN
  function automatic logic imm_out_of_range(input logic [2:0] sel,
                                            input logic signed [31:0] v);
    logic bad;
    bad = 1'b0;
    case (sel)
      SEL_I, SEL_S: bad = (v < -32'sd2048) || (v > 32'sd2047);
      SEL_B:        bad = (v < -32'sd4096) || (v > 32'sd4094) || v[0];
      SEL_U:        bad = (v[11:0] != 12'd0);
      SEL_J:        bad = (v < -32'sd1048576) || (v > 32'sd1048574) || v[0];
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  // Stage p0: combinational encode of the incoming beat
  logic signed [31:0] imm_p0;
  logic [31:0]        instr_p0;
  logic               sel_err_p0;
  logic               range_err_p0;
  logic               err_p0;
  logic               unused_imm_lsb;

  assign imm_p0         = imm;
  assign instr_p0       = pack_imm(imm_sel, imm_p0, base_instr);
  assign sel_err_p0     = (imm_sel > SEL_J);
  assign unused_imm_lsb = imm[0];
`ifdef IMM_ENC_STRICT_EN
  assign range_err_p0   = imm_out_of_range(imm_sel, imm_p0);
`else
  assign range_err_p0   = 1'b0;
`endif
  assign err_p0         = sel_err_p0 | range_err_p0;

  // Stage p1: output register plus one skid entry
  logic        vld_p1;
  logic [31:0] instr_p1;
  logic        err_p1;
  logic        skid_vld;
  logic [31:0] skid_instr;
  logic        skid_err;
  logic        in_fire;
  logic        out_fire;
  logic        load_out;
  logic        to_skid;

  assign in_ready  = !skid_vld;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = vld_p1 && out_ready;
  assign load_out  = !vld_p1 || out_ready;
  assign to_skid   = in_fire && vld_p1 && !out_ready;

  assign out_valid = vld_p1;
  assign out_instr = instr_p1;
  assign out_err   = err_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      instr_p1 <= 32'd0;
      err_p1   <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (load_out) begin
        vld_p1 <= skid_vld | in_fire;
        if (skid_vld) begin
          instr_p1 <= skid_instr;
          err_p1   <= skid_err;
        end else if (in_fire) begin
          instr_p1 <= instr_p0;
          err_p1   <= err_p0;
        end
      end
      // in_ready is low while the skid is full, so it can only drain here, never refill.
      if (skid_vld && out_fire) begin
        skid_vld <= 1'b0;
      end else if (to_skid) begin
        skid_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (to_skid) begin
      skid_instr <= instr_p0;
      skid_err   <= err_p0;
    end
  end

  // Error counter on handed-off beats; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (out_fire && err_p1 && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: vector table streamed through a scoreboard,
// plus hand-written latency, backpressure, counter and reset-during-stall sequences.
`timescale 1ns/1ps
module tb_imm_encoder;
  localparam int ERR_CNT_W = 8;
`ifdef IMM_ENC_STRICT_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           imm_sel;
  logic [31:0]          imm;
  logic [31:0]          base_instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic                 out_err;
  logic                 err_clr;
  logic [ERR_CNT_W-1:0] err_count;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t drv_exp;
  int   n_vec;
  int   n_miss;

  imm_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_sel   (imm_sel),
    .imm       (imm),
    .base_instr(base_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [31:0] v,
                              input logic [31:0] base, input logic [31:0] ei,
                              input logic ee);
    vec_t r;
    r.sel = sel; r.imm = v; r.base = base; r.exp_instr = ei; r.exp_err = ee;
    return r;
  endfunction

  task automatic add(input logic [2:0] sel, input logic [31:0] v, input logic [31:0] base,
                     input logic [31:0] ei, input logic ee);
    tbl.push_back(mk(sel, v, base, ei, ee));
  endtask

  task automatic drive(input vec_t v);
    in_valid      = 1'b1;
    imm_sel       = v.sel;
    imm           = v.imm;
    base_instr    = v.base;
    drv_exp.instr = v.exp_instr;
    drv_exp.err   = v.exp_err;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Called at a falling edge with inputs set: records what the next rising edge will
  // transfer, then advances to the following falling edge.
  task automatic tick();
    exp_t e;
    #1;
    if (in_valid && in_ready) sb.push_back(drv_exp);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", out_instr, e.instr);
        chk("sb_err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 6 && sb.size() != 0; k++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t b1, b2, b3;
    int   nerr;
    n_vec = 0; n_miss = 0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    imm_sel = 3'd0; imm = 32'd0; base_instr = 32'd0;
    drv_exp.instr = 32'd0; drv_exp.err = 1'b0;

    add(3'd0, 32'hFFFF_FFFC, 32'h0004_A303, 32'hFFC4_A303, 1'b0);
    add(3'd1, 32'h0000_0008, 32'h0064_A023, 32'h0064_A423, 1'b0);
    add(3'd2, 32'hFFFF_FFF4, 32'h0042_0063, 32'hFE42_0AE3, 1'b0);
    add(3'd3, 32'h1234_5000, 32'h0000_0537, 32'h1234_5537, 1'b0);
    add(3'd4, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
    add(3'd4, 32'hFFFF_FFFE, 32'h0000_00EF, 32'hFFFF_F0EF, 1'b0);
    add(3'd0, 32'h0000_0001, 32'hFFF0_0013, 32'h0010_0013, 1'b0);
    add(3'd0, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0);
    add(3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
    add(3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, STRICT);
    add(3'd1, 32'hFFFF_F7FF, 32'h0000_2023, 32'h7E00_2FA3, STRICT);
    add(3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, STRICT);
    add(3'd2, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
    add(3'd2, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, STRICT);
    add(3'd3, 32'h0000_1001, 32'h0000_0037, 32'h0000_1037, STRICT);
    add(3'd4, 32'h0010_0000, 32'h0000_00EF, 32'h8000_00EF, STRICT);
    add(3'd4, 32'h0000_0001, 32'h0000_00EF, 32'h0000_00EF, STRICT);
    add(3'd5, 32'h0000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    add(3'd6, 32'h0000_0005, 32'h1234_5678, 32'h1234_5678, 1'b1);
    add(3'd7, 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single beat latency
    drive(tbl[0]);
    tick();
    idle();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_instr", out_instr, 32'hFFC4_A303);
    tick();
    chk("lat_gone", {31'd0, out_valid}, 32'd0);

    // Range error counted only in strict builds
    drive(mk(3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, STRICT));
    tick();
    idle();
    tick();
    chk("strict_cnt", 32'(err_count), {31'd0, STRICT});

    // Table streamed back to back
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    nerr = 0;
    foreach (tbl[i]) nerr += int'(tbl[i].exp_err);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      chk("thru_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    idle();
    drain();
    chk("tbl_err_count", 32'(err_count), 32'(nerr));

    // Backpressure: two beats fit, the third waits
    b1 = mk(3'd1, 32'h0000_0008, 32'h0064_A023, 32'h0064_A423, 1'b0);
    b2 = mk(3'd6, 32'h0000_0000, 32'h5555_AAAA, 32'h5555_AAAA, 1'b1);
    b3 = mk(3'd3, 32'h1234_5000, 32'h0000_0537, 32'h1234_5537, 1'b0);
    out_ready = 1'b0;
    drive(b1); tick();
    drive(b2); tick();
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_hold", out_instr, b1.exp_instr);
    drive(b3); tick();
    chk("bp_ready_low2", {31'd0, in_ready}, 32'd0);
    chk("bp_hold2", out_instr, b1.exp_instr);
    out_ready = 1'b1;
    tick();
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    chk("bp_last_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Saturation, then clear racing an error handoff
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    for (int i = 0; i < (1 << ERR_CNT_W) + 3; i++) begin
      drive(mk(3'd6, 32'(i), 32'hC0DE_0000 + 32'(i), 32'hC0DE_0000 + 32'(i), 1'b1));
      tick();
    end
    idle();
    drain();
    chk("cnt_saturated", 32'(err_count), 32'h0000_00FF);
    drive(mk(3'd7, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1));
    tick();
    idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_wins", 32'(err_count), 32'd0);
    drive(mk(3'd5, 32'd0, 32'h0000_1111, 32'h0000_1111, 1'b1));
    tick();
    idle();
    tick();
    chk("cnt_inc", 32'(err_count), 32'd1);

    // Asynchronous reset while stalled with the skid full
    out_ready = 1'b0;
    drive(b1); tick();
    drive(b2); tick();
    idle();
    chk("stall_skid_full", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    drive(mk(3'd3, 32'h1234_5000, 32'h0000_0537, 32'h1234_5537, 1'b0));
    tick();
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
